// File: rtl/lsu_arbiter.sv
// Two-master round-robin arbiter and single-outstanding access sequencer
// sitting in front of the load/store unit.
module lsu_arbiter #(
  parameter int RD_LAT = 1,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_m0_req,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_wdata,
  input  logic          i_m0_wren,
  input  logic [1:0]    i_m0_size,
  output logic          o_m0_gnt,
  output logic          o_m0_done,
  output logic [DW-1:0] o_m0_rdata,
  input  logic          i_m1_req,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_wdata,
  input  logic          i_m1_wren,
  input  logic [1:0]    i_m1_size,
  output logic          o_m1_gnt,
  output logic          o_m1_done,
  output logic [DW-1:0] o_m1_rdata,
  output logic [AW-1:0] o_lsu_addr,
  output logic [DW-1:0] o_lsu_st_data,
  output logic [1:0]    o_lsu_size,
  output logic          o_lsu_wren,
  input  logic [DW-1:0] i_ld_data,
  output logic          o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] CNT_INIT =
    (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  state_t        state_q, state_d;
  logic [AW-1:0] cmd_addr_q;
  logic [DW-1:0] cmd_wdata_q;
  logic          cmd_wren_q;
  logic [1:0]    cmd_size_q;
  logic          owner_q;
  logic          last_gnt_q;
  logic [2:0]    cnt_q;

  logic win0, win1, done;

  always_comb begin
    win0    = 1'b0;
    win1    = 1'b0;
    done    = 1'b0;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        // on a tie the master that did not win last time goes first
        win0 = i_m0_req & (~i_m1_req | last_gnt_q);
        win1 = i_m1_req & (~i_m0_req | ~last_gnt_q);
        if (win0 | win1) state_d = ISSUE;
      end
      ISSUE: begin
        if (RD_LAT == 0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wren_q  <= 1'b0;
      cmd_size_q  <= 2'b00;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      cnt_q       <= 3'd0;
    end else begin
      state_q <= state_d;
      if (win0 | win1) begin
        owner_q     <= win1;
        last_gnt_q  <= win1;
        cmd_addr_q  <= win1 ? i_m1_addr  : i_m0_addr;
        cmd_wdata_q <= win1 ? i_m1_wdata : i_m0_wdata;
        cmd_wren_q  <= win1 ? i_m1_wren  : i_m0_wren;
        cmd_size_q  <= win1 ? i_m1_size  : i_m0_size;
      end
      if (state_q == ISSUE) cnt_q <= CNT_INIT;
      else if (state_q == WAIT) cnt_q <= cnt_q - 3'd1;
    end
  end

  // a reset cycle never grants or completes anything
  assign o_m0_gnt  = win0 & ~i_reset;
  assign o_m1_gnt  = win1 & ~i_reset;
  assign o_m0_done = done & ~owner_q & ~i_reset;
  assign o_m1_done = done &  owner_q & ~i_reset;

  assign o_m0_rdata = (o_m0_done & ~cmd_wren_q) ? i_ld_data : '0;
  assign o_m1_rdata = (o_m1_done & ~cmd_wren_q) ? i_ld_data : '0;

  assign o_lsu_addr    = cmd_addr_q;
  assign o_lsu_st_data = cmd_wdata_q;
  assign o_lsu_size    = cmd_size_q;
  assign o_lsu_wren    = (state_q == ISSUE) & cmd_wren_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: an RD_LAT=1 and an RD_LAT=0 instance share stimulus
// and are checked every cycle against a timeline model of each transaction.
module tb_lsu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd, ld_data;
  logic        m0_wr, m1_wr;
  logic [1:0]  m0_sz, m1_sz;

  logic        g0 [2], g1 [2], d0 [2], d1 [2];
  logic [31:0] r0 [2], r1 [2], la [2], ls [2];
  logic [1:0]  lz [2];
  logic        lw [2], bz [2];

  lsu_arbiter #(.RD_LAT(1)) u_dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wd),
    .i_m0_wren(m0_wr), .i_m0_size(m0_sz),
    .o_m0_gnt(g0[0]), .o_m0_done(d0[0]), .o_m0_rdata(r0[0]),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wd),
    .i_m1_wren(m1_wr), .i_m1_size(m1_sz),
    .o_m1_gnt(g1[0]), .o_m1_done(d1[0]), .o_m1_rdata(r1[0]),
    .o_lsu_addr(la[0]), .o_lsu_st_data(ls[0]), .o_lsu_size(lz[0]),
    .o_lsu_wren(lw[0]), .i_ld_data(ld_data), .o_busy(bz[0])
  );

  lsu_arbiter #(.RD_LAT(0)) u_dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wd),
    .i_m0_wren(m0_wr), .i_m0_size(m0_sz),
    .o_m0_gnt(g0[1]), .o_m0_done(d0[1]), .o_m0_rdata(r0[1]),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wd),
    .i_m1_wren(m1_wr), .i_m1_size(m1_sz),
    .o_m1_gnt(g1[1]), .o_m1_done(d1[1]), .o_m1_rdata(r1[1]),
    .o_lsu_addr(la[1]), .o_lsu_st_data(ls[1]), .o_lsu_size(lz[1]),
    .o_lsu_wren(lw[1]), .i_ld_data(ld_data), .o_busy(bz[1])
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // model: each transaction is a set of cycle numbers on a timeline
  int          lat     [2] = '{1, 0};
  bit          valid   [2] = '{0, 0};
  int          free_at [2];
  int          iss_at  [2];
  int          dn_at   [2];
  bit          own     [2];
  bit          lst     [2];
  logic [31:0] c_addr  [2];
  logic [31:0] c_wd    [2];
  logic        c_wr    [2];
  logic [1:0]  c_sz    [2];
  bit          eg0     [2];
  bit          eg1     [2];

  // snapshot of outputs at the last checked cycle
  logic        s_g0 [2], s_g1 [2], s_d0 [2], s_d1 [2], s_w [2], s_b [2];
  logic [31:0] s_r0 [2], s_r1 [2], s_a [2], s_s [2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check(input int k);
    bit idle, dn, e_d0, e_d1;
    logic [31:0] e_r0, e_r1;
    idle = (cyc >= free_at[k]);
    eg0[k] = !rst && idle && m0_req && (!m1_req || lst[k]);
    eg1[k] = !rst && idle && m1_req && (!m0_req || !lst[k]);
    dn   = !rst && (cyc == dn_at[k]);
    e_d0 = dn && !own[k];
    e_d1 = dn && own[k];
    e_r0 = (e_d0 && !c_wr[k]) ? ld_data : 32'h0;
    e_r1 = (e_d1 && !c_wr[k]) ? ld_data : 32'h0;
    chk($sformatf("c%0d k%0d gnt0", cyc, k), 64'(g0[k]), 64'(eg0[k]));
    chk($sformatf("c%0d k%0d gnt1", cyc, k), 64'(g1[k]), 64'(eg1[k]));
    chk($sformatf("c%0d k%0d done0", cyc, k), 64'(d0[k]), 64'(e_d0));
    chk($sformatf("c%0d k%0d done1", cyc, k), 64'(d1[k]), 64'(e_d1));
    chk($sformatf("c%0d k%0d rdata0", cyc, k), 64'(r0[k]), 64'(e_r0));
    chk($sformatf("c%0d k%0d rdata1", cyc, k), 64'(r1[k]), 64'(e_r1));
    chk($sformatf("c%0d k%0d addr", cyc, k), 64'(la[k]), 64'(c_addr[k]));
    chk($sformatf("c%0d k%0d stdata", cyc, k), 64'(ls[k]), 64'(c_wd[k]));
    chk($sformatf("c%0d k%0d size", cyc, k), 64'(lz[k]), 64'(c_sz[k]));
    chk($sformatf("c%0d k%0d wren", cyc, k), 64'(lw[k]),
        64'((cyc == iss_at[k]) && c_wr[k]));
    chk($sformatf("c%0d k%0d busy", cyc, k), 64'(bz[k]), 64'(!idle));
  endtask

  task automatic model_update(input int k);
    if (rst) begin
      valid[k]   = 1'b1;
      free_at[k] = cyc + 1;
      iss_at[k]  = -1;
      dn_at[k]   = -1;
      own[k]     = 1'b0;
      lst[k]     = 1'b1;
      c_addr[k]  = '0;
      c_wd[k]    = '0;
      c_wr[k]    = 1'b0;
      c_sz[k]    = '0;
    end else if (eg0[k] || eg1[k]) begin
      own[k]     = eg1[k];
      lst[k]     = eg1[k];
      c_addr[k]  = eg1[k] ? m1_addr : m0_addr;
      c_wd[k]    = eg1[k] ? m1_wd   : m0_wd;
      c_wr[k]    = eg1[k] ? m1_wr   : m0_wr;
      c_sz[k]    = eg1[k] ? m1_sz   : m0_sz;
      iss_at[k]  = cyc + 1;
      dn_at[k]   = cyc + 1 + lat[k];
      free_at[k] = cyc + 2 + lat[k];
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      eg0[k] = 1'b0;
      eg1[k] = 1'b0;
      if (valid[k]) model_check(k);
      s_g0[k] = g0[k]; s_g1[k] = g1[k];
      s_d0[k] = d0[k]; s_d1[k] = d1[k];
      s_r0[k] = r0[k]; s_r1[k] = r1[k];
      s_a[k]  = la[k]; s_s[k]  = ls[k];
      s_w[k]  = lw[k]; s_b[k]  = bz[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k);
    cyc++;
    #1;
  endtask

  task automatic idle_in();
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_in();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle_in();
    m0_addr = '0; m1_addr = '0; m0_wd = '0; m1_wd = '0;
    m0_wr = 1'b0; m1_wr = 1'b0; m0_sz = 2'b00; m1_sz = 2'b00;
    ld_data = '0;
    #1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst busy", 64'(s_b[0]), 64'd0);
    chk("rst addr", 64'(s_a[0]), 64'd0);

    // m0 load, RD_LAT=1
    m0_req = 1'b1; m0_addr = 32'h10; m0_wr = 1'b0; m0_sz = 2'b10;
    ld_data = 32'hDEAD_BEEF;
    step();
    chk("t1 gnt0 T", 64'(s_g0[0]), 64'd1);
    m0_req = 1'b0;
    step();
    chk("t1 addr T+1", 64'(s_a[0]), 64'h10);
    chk("t1 wren T+1", 64'(s_w[0]), 64'd0);
    step();
    chk("t1 addr T+2", 64'(s_a[0]), 64'h10);
    chk("t1 done0 T+2", 64'(s_d0[0]), 64'd1);
    chk("t1 rdata0 T+2", 64'(s_r0[0]), 64'hDEAD_BEEF);
    chk("t1 done1 T+2", 64'(s_d1[0]), 64'd0);
    step();

    // m1 store
    m1_req = 1'b1; m1_addr = 32'h7000; m1_wd = 32'hFF;
    m1_wr = 1'b1; m1_sz = 2'b10;
    step();
    chk("t2 gnt1 T", 64'(s_g1[0]), 64'd1);
    m1_req = 1'b0;
    step();
    chk("t2 wren T+1", 64'(s_w[0]), 64'd1);
    chk("t2 stdata T+1", 64'(s_s[0]), 64'hFF);
    step();
    chk("t2 wren T+2", 64'(s_w[0]), 64'd0);
    chk("t2 done1 T+2", 64'(s_d1[0]), 64'd1);
    chk("t2 rdata1 T+2", 64'(s_r1[0]), 64'd0);
    step();

    // both masters request continuously from reset
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b0; m1_wr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t3 gnt0 i%0d", i), 64'(s_g0[0]), 64'(i % 6 == 0));
      chk($sformatf("t3 gnt1 i%0d", i), 64'(s_g1[0]), 64'(i % 6 == 3));
    end

    // m1 raises req while m0 is in flight
    do_reset();
    m0_req = 1'b1; m0_wr = 1'b0;
    step();
    chk("t4 gnt0 T", 64'(s_g0[0]), 64'd1);
    m0_req = 1'b0; m1_req = 1'b1; m1_wr = 1'b0;
    step();
    chk("t4 gnt1 T+1", 64'(s_g1[0]), 64'd0);
    step();
    chk("t4 gnt1 T+2", 64'(s_g1[0]), 64'd0);
    step();
    chk("t4 gnt1 T+3", 64'(s_g1[0]), 64'd1);
    m1_req = 1'b0;
    step(); step(); step();

    // reset during WAIT of an m0 load
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h20; m0_wr = 1'b0;
    step();
    m0_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("t5 done0 in reset", 64'(s_d0[0]), 64'd0);
    rst = 1'b0; m1_req = 1'b1; m1_wr = 1'b0;
    step();
    chk("t5 wren after", 64'(s_w[0]), 64'd0);
    chk("t5 addr after", 64'(s_a[0]), 64'd0);
    chk("t5 busy after", 64'(s_b[0]), 64'd0);
    chk("t5 gnt1 after", 64'(s_g1[0]), 64'd1);
    m1_req = 1'b0;
    step(); step(); step();

    // RD_LAT=0 instance, m0 load
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h44; m0_wr = 1'b0;
    step();
    chk("t6 gnt0 T", 64'(s_g0[1]), 64'd1);
    m0_req = 1'b0; ld_data = 32'h1234_5678;
    step();
    chk("t6 done0 T+1", 64'(s_d0[1]), 64'd1);
    chk("t6 rdata0 T+1", 64'(s_r0[1]), 64'h1234_5678);
    m0_req = 1'b1; m0_addr = 32'h48;
    step();
    chk("t6 gnt0 T+2", 64'(s_g0[1]), 64'd1);
    m0_req = 1'b0;
    step(); step();

    // random traffic, both instances checked against the model
    for (int i = 0; i < 800; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      m0_req  = 1'($urandom_range(0, 1));
      m1_req  = 1'($urandom_range(0, 1));
      m0_addr = $urandom; m1_addr = $urandom;
      m0_wd   = $urandom; m1_wd   = $urandom;
      m0_wr   = 1'($urandom_range(0, 1));
      m1_wr   = 1'($urandom_range(0, 1));
      m0_sz   = 2'($urandom_range(0, 2));
      m1_sz   = 2'($urandom_range(0, 2));
      ld_data = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Two-master arbiter and access sequencer in front of the core's load/store unit (LSU).
- Master 0 is the core data port; master 1 is a secondary requester (debug loader / DMA).
- Each accepted request becomes a single LSU transaction: ISSUE, then a fixed read-latency wait, then a completion pulse back to the owning master.
- Round-robin priority; one outstanding transaction at a time.

Parameters:
- RD_LAT, 1, LSU load-data latency in cycles after the address is presented (0 = combinational read; legal range 0..7).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_m0_req  in  1  master 0 request; addr/wdata/wren/size held stable until grant.
- i_m0_addr  in  AW  master 0 byte address.
- i_m0_wdata  in  DW  master 0 store data.
- i_m0_wren  in  1  master 0 store (1) / load (0).
- i_m0_size  in  2  master 0 access size (00 byte, 01 half, 10 word).
- o_m0_gnt  out  1  master 0 request accepted this cycle.
- o_m0_done  out  1  master 0 transaction complete (one-cycle pulse).
- o_m0_rdata  out  DW  master 0 load data; valid only with o_m0_done on a load.
- i_m1_req, i_m1_addr, i_m1_wdata, i_m1_wren, i_m1_size, o_m1_gnt, o_m1_done, o_m1_rdata: identical set for master 1.
- o_lsu_addr  out  AW  to LSU i_lsu_addr.
- o_lsu_st_data  out  DW  to LSU i_st_data.
- o_lsu_size  out  2  to LSU i_lsu_size.
- o_lsu_wren  out  1  to LSU i_lsu_wren.
- i_ld_data  in  DW  from LSU o_ld_data.
- o_busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- States: IDLE, ISSUE, WAIT. Registers:
  - cmd_{addr, wdata, wren, size}
  - owner (1 bit)
  - last_gnt (1 bit)
  - wait counter (3 bits)
- Reset:
  - State goes to IDLE; last_gnt = 1, so master 0 wins the first tie.
  - Command registers, o_lsu_* and counter cleared to 0; all gnt/done/rdata = 0; o_busy = 0.
  - Reset mid-transaction abandons it silently: no done pulse, and o_lsu_wren is 0 from the next cycle.
- IDLE, arbitration:
  - gnt is combinational from req and is asserted only in IDLE.
  - Exactly one master requesting: that master is granted.
  - Both requesting: the master != last_gnt is granted.
  - On grant at cycle T: latch the winner's command, set owner and last_gnt, and move to ISSUE at T+1.
- While not IDLE: both gnt outputs are 0. Requests are held off, not queued; a master may drop req before grant with no side effect.
- ISSUE (cycle T+1):
  - o_lsu_addr/st_data/size come from the command registers.
  - o_lsu_wren = cmd_wren in this cycle only.
  - If RD_LAT = 0: done pulses to the owner this cycle, then go to IDLE.
  - Else: load the counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - o_lsu_addr/size are held and o_lsu_wren = 0.
  - Decrement the counter each cycle. When the counter is 0, pulse done to the owner and go to IDLE.
  - Completion therefore lands at T+1+RD_LAT.
- Done and rdata:
  - Stores also produce a done pulse, at the same cycle position as loads.
  - o_mX_rdata = i_ld_data when o_mX_done is high and cmd_wren = 0; otherwise 0.
  - The non-owner's done and rdata stay 0.
- Throughput: the next grant is possible in the IDLE cycle T+2+RD_LAT; there is no back-to-back issue.
- o_lsu_wren is never high outside ISSUE. o_busy = (state != IDLE).

Test Plan:
1. RD_LAT=1. Reset, then m0 load from addr 0x0000_0010 with LSU returning 0xDEAD_BEEF.
   -> o_m0_gnt at T, o_lsu_addr=0x10 at T+1 and T+2, o_m0_done with o_m0_rdata=0xDEAD_BEEF at T+2, o_m1_done stays 0.
2. m1 store 0x0000_00FF to 0x7000 (size 10).
   -> o_lsu_wren=1 only at T+1, o_lsu_st_data=0xFF, o_m1_done at T+2, o_m1_rdata=0.
3. Both masters request continuously from reset.
   -> grants alternate m0, m1, m0, m1 at cycles 1, 4, 7, 10; no gnt in ISSUE/WAIT cycles.
4. m1 raises req while m0's transaction is in WAIT.
   -> o_m1_gnt=0 until IDLE, then granted on the first IDLE cycle, since last_gnt=0.
5. Assert i_reset during WAIT of an m0 load.
   -> no done pulse; all outputs 0 the next cycle; the next m1 request is granted immediately from IDLE.
6. RD_LAT=0 build, m0 load.
   -> o_m0_done at T+1 with rdata equal to that cycle's i_ld_data; next grant possible at T+2.
